// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU render sequencer: FSM encoding and default
// screen/tile geometry.
package ppu_pkg;

    localparam int PPU_H_PIXELS = 256;
    localparam int PPU_V_PIXELS = 240;
    localparam int PPU_TILE_W   = 8;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_COL_REQ   = 4'd1,
        ST_COL_WAIT  = 4'd2,
        ST_SPR_REQ   = 4'd3,
        ST_SPR_WAIT  = 4'd4,
        ST_TILE_REQ  = 4'd5,
        ST_TILE_WAIT = 4'd6,
        ST_HBLANK    = 4'd7,
        ST_VBLANK    = 4'd8
    } ppu_state_t;

endpackage

// File: rtl/ppu_req_handshake.sv
// Start/busy handshake for one sub-engine: start follows the request level and
// a down-counter abandons the request after TIMEOUT cycles without busy.
module ppu_req_handshake #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_busy,
    output logic o_start,
    output logic o_ack,
    output logic o_timeout
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] r_tmr;
    logic             w_tc;

    assign w_tc      = (r_tmr == '0);
    assign o_start   = i_req;
    // Busy on the terminal cycle wins over the timeout.
    assign o_ack     = i_req & i_busy;
    assign o_timeout = i_req & ~i_busy & w_tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr <= '0;
        end else if (!i_req || o_ack || o_timeout) begin
            r_tmr <= TMR_LOAD;
        end else begin
            r_tmr <= r_tmr - 1'b1;
        end
    end

endmodule

// File: rtl/ppu_render_seq.sv
// PPU render sequencer: loads colors once per frame, then per row evaluates
// sprites and walks the tile engine across the row, pacing with hblank/vblank.
module ppu_render_seq
    import ppu_pkg::*;
#(
    parameter int H_PIXELS    = PPU_H_PIXELS,
    parameter int V_PIXELS    = PPU_V_PIXELS,
    parameter int TILE_W      = PPU_TILE_W,
    parameter int CNT_W       = 16,
    parameter int REQ_TIMEOUT = 64,
    localparam int FX_W  = (TILE_W > 1) ? $clog2(TILE_W) : 1,
    localparam int ROW_W = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1,
    localparam int COL_W = $clog2(H_PIXELS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vga_done,
    input  logic             i_render_en,
    input  logic [FX_W-1:0]  i_fine_x,
    input  logic [CNT_W-1:0] i_hblank_cycles,
    output logic             o_color_start,
    input  logic             i_color_busy,
    output logic             o_sprite_start,
    input  logic             i_sprite_busy,
    output logic             o_tile_start,
    input  logic             i_tile_busy,
    output logic [ROW_W-1:0] o_pix_row,
    output logic [COL_W-1:0] o_pix_col,
    output logic             o_latch_x,
    output logic             o_latch_y,
    output logic             o_vsync,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic             o_hs_err,
    input  logic             i_err_clr
);

    // state | meaning: IDLE wait for display release | COL_* palette load | SPR_* sprite eval
    // TILE_* tile draw, TILE_W px each | HBLANK end-of-row gap | VBLANK wait for vga_done low

    ppu_state_t       r_state, w_next;
    logic [ROW_W-1:0] r_pix_row;
    logic [COL_W-1:0] r_pix_col;
    logic [CNT_W-1:0] r_hb_cnt;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_latch_x, r_latch_y, r_vsync, r_hs_err;

    logic w_col_ack, w_col_to, w_spr_ack, w_spr_to, w_tile_ack, w_tile_to;
    logic w_any_to;
    logic w_start_frame, w_tile_step, w_row_adv, w_frame_end, w_tile_fin;
    logic w_row_end, w_last_row;
    logic [COL_W-1:0] w_col_origin;
    logic [COL_W:0]   w_col_reach;

    ppu_req_handshake #(.TIMEOUT(REQ_TIMEOUT)) u_col_hs (
        .clk       (clk),
        .rst       (rst),
        .i_req     (r_state == ST_COL_REQ),
        .i_busy    (i_color_busy),
        .o_start   (o_color_start),
        .o_ack     (w_col_ack),
        .o_timeout (w_col_to)
    );

    ppu_req_handshake #(.TIMEOUT(REQ_TIMEOUT)) u_spr_hs (
        .clk       (clk),
        .rst       (rst),
        .i_req     (r_state == ST_SPR_REQ),
        .i_busy    (i_sprite_busy),
        .o_start   (o_sprite_start),
        .o_ack     (w_spr_ack),
        .o_timeout (w_spr_to)
    );

    ppu_req_handshake #(.TIMEOUT(REQ_TIMEOUT)) u_tile_hs (
        .clk       (clk),
        .rst       (rst),
        .i_req     (r_state == ST_TILE_REQ),
        .i_busy    (i_tile_busy),
        .o_start   (o_tile_start),
        .o_ack     (w_tile_ack),
        .o_timeout (w_tile_to)
    );

    assign w_any_to     = w_col_to | w_spr_to | w_tile_to;
    assign w_col_origin = COL_W'(0) - COL_W'(i_fine_x);
    // One extra bit so the column reach past the right edge cannot wrap.
    assign w_col_reach  = {1'b0, r_pix_col} + (COL_W+1)'(TILE_W);
    assign w_row_end    = ~r_pix_col[COL_W-1] && (w_col_reach >= (COL_W+1)'(H_PIXELS));
    assign w_last_row   = (r_pix_row == ROW_W'(V_PIXELS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_start_frame = 1'b0;
        w_tile_step   = 1'b0;
        w_row_adv     = 1'b0;
        w_frame_end   = 1'b0;
        w_tile_fin    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_vga_done && i_render_en) begin
                    w_next        = ST_COL_REQ;
                    w_start_frame = 1'b1;
                end
            end
            ST_COL_REQ: begin
                if (w_col_ack)     w_next = ST_COL_WAIT;
                else if (w_col_to) w_next = ST_SPR_REQ;
            end
            ST_COL_WAIT: begin
                if (!i_color_busy) w_next = ST_SPR_REQ;
            end
            ST_SPR_REQ: begin
                if (w_spr_ack)     w_next = ST_SPR_WAIT;
                else if (w_spr_to) w_next = ST_TILE_REQ;
            end
            ST_SPR_WAIT: begin
                if (!i_sprite_busy) w_next = ST_TILE_REQ;
            end
            ST_TILE_REQ: begin
                if (w_tile_ack)     w_next = ST_TILE_WAIT;
                else if (w_tile_to) w_tile_fin = 1'b1;
            end
            ST_TILE_WAIT: begin
                if (!i_tile_busy) w_tile_fin = 1'b1;
            end
            ST_HBLANK: begin
                if (r_hb_cnt == '0) w_next = ST_SPR_REQ;
            end
            ST_VBLANK: begin
                if (!i_vga_done) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase

        if (w_tile_fin) begin
            if (!w_row_end) begin
                w_next      = ST_TILE_REQ;
                w_tile_step = 1'b1;
            end else if (w_last_row) begin
                w_next      = ST_VBLANK;
                w_frame_end = 1'b1;
            end else begin
                w_next    = ST_HBLANK;
                w_row_adv = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_row   <= '0;
            r_pix_col   <= '0;
            r_hb_cnt    <= '0;
            r_frame_cnt <= '0;
            r_latch_x   <= 1'b0;
            r_latch_y   <= 1'b0;
            r_vsync     <= 1'b0;
            r_hs_err    <= 1'b0;
        end else begin
            r_latch_y <= w_start_frame;
            r_latch_x <= (w_next == ST_SPR_REQ) && (r_state != ST_SPR_REQ);
            r_vsync   <= w_frame_end;

            // fine_x only matters at row start; the origin is captured here.
            if (w_start_frame) begin
                r_pix_row <= '0;
                r_pix_col <= w_col_origin;
            end else if (w_tile_step) begin
                r_pix_col <= r_pix_col + COL_W'(TILE_W);
            end else if (w_row_adv) begin
                r_pix_row <= r_pix_row + 1'b1;
                r_pix_col <= w_col_origin;
            end

            if (w_row_adv) begin
                r_hb_cnt <= i_hblank_cycles;
            end else if ((r_state == ST_HBLANK) && (r_hb_cnt != '0)) begin
                r_hb_cnt <= r_hb_cnt - 1'b1;
            end

            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            if (w_any_to) begin
                r_hs_err <= 1'b1;
            end else if (i_err_clr) begin
                r_hs_err <= 1'b0;
            end
        end
    end

    assign o_pix_row   = r_pix_row;
    assign o_pix_col   = r_pix_col;
    assign o_latch_x   = r_latch_x;
    assign o_latch_y   = r_latch_y;
    assign o_vsync     = r_vsync;
    assign o_frame_cnt = r_frame_cnt;
    assign o_hs_err    = r_hs_err;

endmodule

// File: doc/ppu_render_seq.md
PPU_RENDER_SEQ -- requirements
Module: ppu_render_seq

Interface
REQ-001 Parameter H_PIXELS, default 256, meaning visible pixels per row (multiple of TILE_W).
REQ-002 Parameter V_PIXELS, default 240, meaning visible rows per frame.
REQ-003 Parameter TILE_W, default 8, meaning pixels drawn per tile-engine request (power of 2); FX_W = log2(TILE_W).
REQ-004 Parameter CNT_W, default 16, meaning width of hblank counter and frame counter.
REQ-005 Parameter REQ_TIMEOUT, default 64, meaning cycles a start may wait for busy before abandon.
REQ-006 clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-007 vga_done  in  1  display finished reading frame buffer; render_en  in  1  allow new frames.
REQ-008 fine_x  in  FX_W  horizontal fine scroll; hblank_cycles  in  CNT_W  end-of-row idle length.
REQ-009 color_start out 1 / color_busy in 1; sprite_start out 1 / sprite_busy in 1; tile_start out 1 / tile_busy in 1  sub-engine handshakes.
REQ-010 pix_row  out  clog2(V_PIXELS)  current row; pix_col  out  COL_W=clog2(H_PIXELS)+1  signed two's-complement current column.
REQ-011 latch_x  out 1  row-start scroll latch strobe; latch_y  out 1  frame-start scroll latch strobe.
REQ-012 vsync  out 1  frame-complete pulse; frame_cnt  out CNT_W; hs_err  out 1  sticky timeout flag; err_clr  in 1  clears hs_err.

Function
REQ-013 States: IDLE, COL_REQ, COL_WAIT, SPR_REQ, SPR_WAIT, TILE_REQ, TILE_WAIT, HBLANK, VBLANK.
REQ-014 IDLE: vga_done=1 and render_en=1 -> COL_REQ; pix_row<=0; pix_col<=-fine_x; latch_y pulses 1 cycle.
REQ-015 Each *_REQ state holds its start high; busy=1 -> start deasserted next edge, go to matching *_WAIT.
REQ-016 *_REQ timeout: REQ_TIMEOUT cycles without busy -> start dropped, hs_err set, proceed as if engine completed.
REQ-017 COL_WAIT: busy=0 -> SPR_REQ; colors load once per frame only.
REQ-018 Entry to SPR_REQ pulses latch_x 1 cycle; SPR_WAIT busy=0 -> TILE_REQ.
REQ-019 TILE_WAIT busy=0: if pix_col>=0 and pix_col+TILE_W>=H_PIXELS -> row end; else pix_col+=TILE_W, -> TILE_REQ.
REQ-020 Row end, pix_row==V_PIXELS-1 -> VBLANK, vsync 1-cycle pulse, frame_cnt+=1 (wraps); else pix_row+=1, pix_col<=-fine_x, -> HBLANK.
REQ-021 HBLANK lasts hblank_cycles+1 cycles (0 gives 1), then -> SPR_REQ; counter zeroed on exit.
REQ-022 Tiles per row: H_PIXELS/TILE_W when fine_x=0, H_PIXELS/TILE_W+1 otherwise.
REQ-023 VBLANK: wait vga_done=0 -> IDLE; render_en=0 mid-frame does not abort, only blocks next IDLE exit.
REQ-024 err_clr and simultaneous timeout: set wins; busy arriving on timeout cycle counts as success.
REQ-025 fine_x sampled only at row start; changes mid-row ignored.

Reset
REQ-026 rst=0 from any state: state IDLE, all starts/strobes/vsync 0, pix_row 0, pix_col 0, frame_cnt 0, hs_err 0, counters 0.

Structure
REQ-027 Shared package ppu_pkg: state enum encoding, default H_PIXELS/V_PIXELS/TILE_W constants.
REQ-028 One sub-module ppu_req_handshake (start/busy/timeout), instantiated three times.

Verification
REQ-029 Defaults, V_PIXELS=4, fine_x=0, engines ack in 2 cycles -> 32 tile_start/row, pix_col 0..248, one vsync, frame_cnt=1.
REQ-030 fine_x=3 -> first pix_col=-3 (0x1FD), last 253, 33 tile_start per row.
REQ-031 sprite_busy tied 0, REQ_TIMEOUT=16 -> sprite_start high 16 cycles, hs_err=1, tiles proceed; err_clr -> hs_err=0.
REQ-032 hblank_cycles=5 -> exactly 6 cycles between last tile busy fall and next latch_x pulse.
REQ-033 render_en=0 at row 2 -> frame completes, vsync pulses, stays IDLE while vga_done=1 until render_en=1.
REQ-034 rst low during TILE_WAIT -> next cycle all outputs at reset values, restart requires vga_done=1.
